// File: rtl/hex_digits_scan_driver_pkg.sv
// Shared types and constants for the multiplexed hex display driver:
// active-low 7-segment glyph type, glyph table and scan FSM states.
package hex_scan_pkg;

  // Segment order is {g,f,e,d,c,b,a}, active-low (0 = segment lit).
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_BLANK = 7'h7F;

  // Hex glyphs 0-F; b and d are the lowercase forms.
  localparam seg7_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {SCAN_DEAD, SCAN_ON} scan_state_t;

endpackage

// File: rtl/hex_digits_scan_driver_if.sv
// Bus between the hex-digits PIO side (master) and the scan driver (slave):
// value/control inputs toward the driver, display outputs back.
interface hex_digits_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] hex_value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lz;
  logic                    blink;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   dig_sel_n;
  logic [7*NUM_DIGITS-1:0] hex_static;
  logic                    frame_tick;

  modport master (
    output hex_value, dp_mask, blank_lz, blink,
    input  seg_n, dp_n, dig_sel_n, hex_static, frame_tick
  );

  modport slave (
    input  hex_value, dp_mask, blank_lz, blink,
    output seg_n, dp_n, dig_sel_n, hex_static, frame_tick
  );
endinterface

// File: rtl/hex_digits_scan_driver_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment decoder with a blank override.
module hex_to_seg7
  import hex_scan_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output seg7_t      seg
);

  assign seg = blank ? SEG_BLANK : SEG_LUT[nibble];

endmodule

// File: rtl/hex_digits_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver for NUM_DIGITS hex nibbles,
// plus static per-digit segment outputs. New values are taken only at frame
// wrap so the display never tears. Optional blink gating: define HEX_SCAN_BLINK_EN.
module hex_digits_scan_driver
  import hex_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 128
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hex_digits_scan_driver_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_END   = PW'(DEAD_CYCLES);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][3:0] hex_p0;
  logic [NUM_DIGITS-1:0]      dpm_p0;
  logic [NUM_DIGITS-1:0][3:0] disp_p1;
  logic [NUM_DIGITS-1:0]      dpm_p1;
  logic                       load_vld_p1;

  logic [PW-1:0]         presc_q, presc_d;
  logic [DW-1:0]         digit_q;
  logic                  slot_end, wrap;
  scan_state_t           state_q, state_d;
  logic [NUM_DIGITS-1:0] lz_blank;
  seg7_t                 scan_seg;
  seg7_t [NUM_DIGITS-1:0] static_seg, static_next, static_p2;
  logic                  force_off;

  logic [NUM_DIGITS-1:0]   dig_sel_d, dig_sel_p2;
  seg7_t                   seg_d, seg_p2;
  logic                    dp_d, dp_p2;
  logic [7*NUM_DIGITS-1:0] hex_static_p2;
  logic                    tick_p2;

  // ---- stage p0: shadow capture of the PIO value every cycle ----
  // Shadow registers track the PIO output continuously; only wrap consumes them.
  always_ff @(posedge clk) begin
    hex_p0 <= bus.hex_value;
    dpm_p0 <= bus.dp_mask;
  end

  assign slot_end = (presc_q == PRESC_LAST);
  assign wrap     = slot_end && (digit_q == DIGIT_LAST);

  // Slot prescaler and digit counter; digit advances at every slot end.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
      digit_q <= '0;
    end else begin
      presc_q <= presc_d;
      if (slot_end)
        digit_q <= (digit_q == DIGIT_LAST) ? '0 : digit_q + DW'(1);
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= SCAN_DEAD;
    else          state_q <= state_d;
  end

  // Next state follows the next prescaler value: the first DEAD_CYCLES of a slot are dead time.
  always_comb begin
    presc_d = slot_end ? '0 : presc_q + PW'(1);
    state_d = (presc_d < DEAD_END) ? SCAN_DEAD : SCAN_ON;
  end

  // ---- stage p1: frame-synchronous display registers ----
  // Display/dp registers load only at frame wrap; load_vld_p1 marks the fresh contents.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      disp_p1     <= '0;
      dpm_p1      <= '0;
      load_vld_p1 <= 1'b0;
    end else begin
      load_vld_p1 <= wrap;
      if (wrap) begin
        disp_p1 <= hex_p0;
        dpm_p1  <= dpm_p0;
      end
    end
  end

  // Leading-zero blanking: a digit blanks when it and every digit above it are zero; digit 0 never.
  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    lz_blank   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero  = upper_zero && (disp_p1[i] == 4'h0);
      lz_blank[i] = bus.blank_lz && upper_zero && (i != 0);
    end
  end

  hex_to_seg7 u_scan_dec (
    .nibble (disp_p1[digit_q]),
    .blank  (lz_blank[digit_q]),
    .seg    (scan_seg)
  );

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_static
    hex_to_seg7 u_static_dec (
      .nibble (disp_p1[g]),
      .blank  (lz_blank[g]),
      .seg    (static_seg[g])
    );
  end

`ifdef HEX_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] frame_cnt_q;
  logic          blink_phase_q;

  // Frame counter toggles the blink phase every BLINK_FRAMES frames, whether or not blink is requested.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (wrap) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        frame_cnt_q <= frame_cnt_q + FW'(1);
      end
    end
  end

  assign force_off = bus.blink && !blink_phase_q;
`else
  logic unused_blink;
  assign unused_blink = bus.blink;
  assign force_off    = 1'b0;
`endif

  // Output decode: select the active digit while ON; segments always carry the current digit's glyph.
  always_comb begin
    dig_sel_d = '1;
    if (state_q == SCAN_ON && !force_off)
      dig_sel_d[digit_q] = 1'b0;
    seg_d       = scan_seg;
    dp_d        = ~dpm_p1[digit_q];
    static_next = load_vld_p1 ? static_seg : static_p2;
  end

  // ---- stage p2: registered display outputs ----
  // All outputs registered; static segments refresh only in the frame_tick cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seg_p2        <= SEG_BLANK;
      dp_p2         <= 1'b1;
      dig_sel_p2    <= '1;
      static_p2     <= '1;
      hex_static_p2 <= '1;
      tick_p2       <= 1'b0;
    end else begin
      seg_p2        <= seg_d;
      dp_p2         <= dp_d;
      dig_sel_p2    <= dig_sel_d;
      static_p2     <= static_next;
      hex_static_p2 <= force_off ? '1 : static_next;
      tick_p2       <= load_vld_p1;
    end
  end

  assign bus.seg_n      = seg_p2;
  assign bus.dp_n       = dp_p2;
  assign bus.dig_sel_n  = dig_sel_p2;
  assign bus.hex_static = hex_static_p2;
  assign bus.frame_tick = tick_p2;

endmodule

// File: tb/tb_hex_digits_scan_driver.sv
// Self-checking bench for hex_digits_scan_driver (SCAN_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2).
// Blink expectations depend on whether HEX_SCAN_BLINK_EN is defined.
module tb_hex_digits_scan_driver;
  localparam int N            = 4;
  localparam int SCAN_DIV     = 8;
  localparam int DEAD_CYCLES  = 2;
  localparam int BLINK_FRAMES = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    int         dig;
    logic [6:0] seg;
    logic       dp_n;
  } exp_t;

  exp_t sb[$];

  hex_digits_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  hex_digits_scan_driver #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (SCAN_DIV),
    .DEAD_CYCLES  (DEAD_CYCLES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d, input logic blz);
    logic [15:0] upper;
    upper = v >> (4 * d);
    if (d > 0 && blz && upper == 16'h0) return 7'h7F;
    return ref_glyph(v[4*d +: 4]);
  endfunction

  function automatic logic [27:0] exp_static(input logic [15:0] v, input logic blz);
    logic [27:0] r;
    for (int d = 0; d < N; d++) r[7*d +: 7] = exp_seg(v, d, blz);
    return r;
  endfunction

  task automatic push_frame(input logic [15:0] v, input logic [3:0] dpm, input logic blz);
    exp_t e;
    for (int d = 0; d < N; d++) begin
      e.dig  = d;
      e.seg  = exp_seg(v, d, blz);
      e.dp_n = ~dpm[d];
      sb.push_back(e);
    end
  endtask

  task automatic wait_tick(output bit ok);
    ok = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 80; i++) begin
      if (bus.frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: frame_tick not seen within 80 cycles");
    end
  endtask

  task automatic wait_on(input int d, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << d);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.dig_sel_n === want) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL slot_timeout: digit %0d never selected, dig_sel_n=%b", d, bus.dig_sel_n);
    end
  endtask

  task automatic observe_frame(output bit lit, output bit sblank);
    bit done;
    sblank = (bus.hex_static === 28'hFFFFFFF);
    lit    = 1'b0;
    done   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.dig_sel_n !== 4'hF) lit = 1'b1;
      if (bus.frame_tick === 1'b1) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: next frame_tick not seen");
    end
  endtask

  task automatic test_reset;
    reset_n        = 1'b0;
    bus.hex_value  = 16'h1234;
    bus.dp_mask    = 4'h0;
    bus.blank_lz   = 1'b0;
    bus.blink      = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.seg_n, bus.dp_n, bus.dig_sel_n, bus.frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: seg_n=%b dp_n=%b dig_sel_n=%b tick=%b expected 1111111 1 1111 0",
               bus.seg_n, bus.dp_n, bus.dig_sel_n, bus.frame_tick);
    end
    checks++;
    if (bus.hex_static !== 28'hFFFFFFF) begin
      errors++;
      $display("FAIL reset_static: hex_static=%h expected fffffff", bus.hex_static);
    end
    reset_n = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.dig_sel_n !== 4'hF || bus.dp_n !== 1'b1 || bus.frame_tick !== 1'b0 ||
          bus.hex_static !== 28'hFFFFFFF) begin
        errors++;
        $display("FAIL reset_dead_c%0d: dig_sel_n=%b dp_n=%b tick=%b hex_static=%h expected 1111 1 0 fffffff",
                 c, bus.dig_sel_n, bus.dp_n, bus.frame_tick, bus.hex_static);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.dig_sel_n !== 4'b1110) begin
      errors++;
      $display("FAIL reset_first_on: dig_sel_n=%b expected 1110", bus.dig_sel_n);
    end
  endtask

  task automatic test_hex_1234;
    exp_t e;
    bit   ok;
    bus.hex_value = 16'h1234;
    bus.blank_lz  = 1'b0;
    bus.dp_mask   = 4'h0;
    wait_tick(ok);
    if (ok) begin
      checks++;
      if (bus.hex_static[6:0] !== 7'b0011001) begin
        errors++;
        $display("FAIL static_dig0_1234: got %b expected 0011001", bus.hex_static[6:0]);
      end
      checks++;
      if (bus.hex_static !== exp_static(16'h1234, 1'b0)) begin
        errors++;
        $display("FAIL static_1234: got %h expected %h", bus.hex_static, exp_static(16'h1234, 1'b0));
      end
      push_frame(16'h1234, 4'h0, 1'b0);
      for (int k = 0; k < N; k++) begin
        e = sb.pop_front();
        wait_on(e.dig, ok);
        if (ok) begin
          checks++;
          if (bus.seg_n !== e.seg || bus.dp_n !== e.dp_n) begin
            errors++;
            $display("FAIL scan_1234_dig%0d: seg_n=%b dp_n=%b expected %b %b",
                     e.dig, bus.seg_n, bus.dp_n, e.seg, e.dp_n);
          end
        end
      end
    end
  endtask

  task automatic test_lz_blank;
    exp_t e;
    bit   ok;
    bus.hex_value = 16'h0007;
    bus.blank_lz  = 1'b1;
    bus.dp_mask   = 4'b0100;
    wait_tick(ok);
    if (ok) begin
      checks++;
      if (bus.hex_static !== exp_static(16'h0007, 1'b1)) begin
        errors++;
        $display("FAIL static_lz_on: got %h expected %h", bus.hex_static, exp_static(16'h0007, 1'b1));
      end
      push_frame(16'h0007, 4'b0100, 1'b1);
      for (int k = 0; k < N; k++) begin
        e = sb.pop_front();
        wait_on(e.dig, ok);
        if (ok) begin
          checks++;
          if (bus.seg_n !== e.seg || bus.dp_n !== e.dp_n) begin
            errors++;
            $display("FAIL scan_lz_on_dig%0d: seg_n=%b dp_n=%b expected %b %b",
                     e.dig, bus.seg_n, bus.dp_n, e.seg, e.dp_n);
          end
        end
      end
    end
    bus.blank_lz = 1'b0;
    bus.dp_mask  = 4'h0;
    wait_tick(ok);
    if (ok) begin
      push_frame(16'h0007, 4'h0, 1'b0);
      for (int k = 0; k < N; k++) begin
        e = sb.pop_front();
        wait_on(e.dig, ok);
        if (ok) begin
          checks++;
          if (bus.seg_n !== e.seg || bus.dp_n !== e.dp_n) begin
            errors++;
            $display("FAIL scan_lz_off_dig%0d: seg_n=%b dp_n=%b expected %b %b",
                     e.dig, bus.seg_n, bus.dp_n, e.seg, e.dp_n);
          end
        end
      end
    end
  endtask

  task automatic test_midframe_change;
    exp_t e;
    bit   ok;
    bus.hex_value = 16'h1234;
    wait_tick(ok);
    if (!ok) return;
    push_frame(16'h1234, 4'h0, 1'b0);
    for (int k = 0; k < N; k++) begin
      e = sb.pop_front();
      wait_on(e.dig, ok);
      if (ok) begin
        checks++;
        if (bus.seg_n !== e.seg) begin
          errors++;
          $display("FAIL mid_old_dig%0d: seg_n=%b expected %b", e.dig, bus.seg_n, e.seg);
        end
      end
      if (k == 1) bus.hex_value = 16'hABCD;
    end
    checks++;
    if (bus.hex_static !== exp_static(16'h1234, 1'b0)) begin
      errors++;
      $display("FAIL mid_static_held: got %h expected %h", bus.hex_static, exp_static(16'h1234, 1'b0));
    end
    wait_tick(ok);
    if (!ok) return;
    checks++;
    if (bus.hex_static !== exp_static(16'hABCD, 1'b0)) begin
      errors++;
      $display("FAIL mid_static_new: got %h expected %h", bus.hex_static, exp_static(16'hABCD, 1'b0));
    end
    push_frame(16'hABCD, 4'h0, 1'b0);
    for (int k = 0; k < N; k++) begin
      e = sb.pop_front();
      wait_on(e.dig, ok);
      if (ok) begin
        checks++;
        if (bus.seg_n !== e.seg) begin
          errors++;
          $display("FAIL mid_new_dig%0d: seg_n=%b expected %b", e.dig, bus.seg_n, e.seg);
        end
      end
    end
    wait_on(1, ok);
    bus.hex_value = 16'h0000;
    @(negedge clk);
    bus.hex_value = 16'hABCD;
    wait_tick(ok);
    if (!ok) return;
    checks++;
    if (bus.hex_static !== exp_static(16'hABCD, 1'b0)) begin
      errors++;
      $display("FAIL glitch_static: got %h expected %h", bus.hex_static, exp_static(16'hABCD, 1'b0));
    end
    push_frame(16'hABCD, 4'h0, 1'b0);
    for (int k = 0; k < N; k++) begin
      e = sb.pop_front();
      wait_on(e.dig, ok);
      if (ok) begin
        checks++;
        if (bus.seg_n !== e.seg) begin
          errors++;
          $display("FAIL glitch_dig%0d: seg_n=%b expected %b", e.dig, bus.seg_n, e.seg);
        end
      end
    end
  endtask

  task automatic test_dead_time;
    bit ok;
    int run;
    int slots;
    int multi;
    wait_tick(ok);
    if (!ok) return;
    run   = (bus.dig_sel_n === 4'hF) ? 1 : 0;
    slots = 0;
    multi = 0;
    repeat (3 * N * SCAN_DIV) begin
      @(negedge clk);
      if (bus.dig_sel_n === 4'hF) begin
        run++;
      end else begin
        if (run > 0) begin
          slots++;
          checks++;
          if (run != DEAD_CYCLES) begin
            errors++;
            $display("FAIL dead_len_slot%0d: dead cycles=%0d expected %0d", slots, run, DEAD_CYCLES);
          end
        end
        run = 0;
        if ($countones(~bus.dig_sel_n) > 1) multi++;
      end
    end
    checks++;
    if (multi != 0) begin
      errors++;
      $display("FAIL dead_onehot: cycles with >1 select low=%0d expected 0", multi);
    end
    checks++;
    if (slots != 3 * N) begin
      errors++;
      $display("FAIL dead_slot_count: slots=%0d expected %0d", slots, 3 * N);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    wait_on(2, ok);
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.seg_n, bus.dp_n, bus.dig_sel_n, bus.frame_tick} !== {7'h7F, 1'b1, 4'hF, 1'b0} ||
        bus.hex_static !== 28'hFFFFFFF) begin
      errors++;
      $display("FAIL reset_mid: seg_n=%b dp_n=%b dig_sel_n=%b tick=%b hex_static=%h expected blank",
               bus.seg_n, bus.dp_n, bus.dig_sel_n, bus.frame_tick, bus.hex_static);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_blink;
    bit ok;
    bit lit [8];
    bit sblank;
    bus.hex_value = 16'h1234;
    bus.blank_lz  = 1'b0;
    bus.dp_mask   = 4'h0;
    bus.blink     = 1'b1;
    wait_tick(ok);
    if (!ok) return;
    for (int f = 0; f < 8; f++) begin
      observe_frame(lit[f], sblank);
      checks++;
      if (lit[f] == sblank) begin
        errors++;
        $display("FAIL blink_static_f%0d: scan lit=%0d static blank=%0d", f, lit[f], sblank);
      end
    end
`ifdef HEX_SCAN_BLINK_EN
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (lit[k] == lit[k+2]) begin
        errors++;
        $display("FAIL blink_period_f%0d: lit=%0d and frame+2 lit=%0d expected opposite", k, lit[k], lit[k+2]);
      end
    end
`else
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (!lit[k]) begin
        errors++;
        $display("FAIL blink_ignored_f%0d: frame blank, expected lit", k);
      end
    end
`endif
    bus.blink = 1'b0;
    wait_tick(ok);
    if (!ok) return;
    for (int f = 0; f < 4; f++) begin
      observe_frame(lit[f], sblank);
      checks++;
      if (!lit[f] || sblank) begin
        errors++;
        $display("FAIL blink_off_f%0d: lit=%0d static blank=%0d expected lit and not blank", f, lit[f], sblank);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hex_1234();
    test_lz_blank();
    test_midframe_change();
    test_dead_time();
    test_reset_mid();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
